// File: rtl/tl_cpl_assembler.sv
// tl_cpl_assembler: reassembles split read completions per tag and streams payload with per-beat address and DW keep
module tl_cpl_assembler #(
    parameter int TAG_W = 5,
    parameter int DATA_W = 128,
    parameter int MAX_BYTES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpl_valid_i,
    output logic                  cpl_ready_o,
    input  logic                  cpl_sop_i,
    input  logic                  cpl_eop_i,
    input  logic [TAG_W-1:0]      cpl_tag_i,
    input  logic [2:0]            cpl_status_i,
    input  logic [15:0]           cpl_req_id_i,
    input  logic [11:0]           cpl_byte_count_i,
    input  logic [6:0]            cpl_lower_addr_i,
    input  logic [9:0]            cpl_len_i,
    input  logic [DATA_W-1:0]     cpl_data_i,
    output logic [TAG_W-1:0]      lookup_tag_o,
    input  logic                  lookup_hit_i,
    input  logic [15:0]           lookup_req_id_i,
    input  logic [31:0]           lookup_addr_i,
    input  logic [9:0]            lookup_len_i,
    output logic [TAG_W-1:0]      free_tag_o,
    output logic                  free_valid_o,
    output logic [TAG_W-1:0]      usr_rtag_o,
    output logic [31:0]           usr_raddr_o,
    output logic [DATA_W-1:0]     usr_rdata_o,
    output logic [DATA_W/32-1:0]  usr_rkeep_o,
    output logic                  usr_rvalid_o,
    input  logic                  usr_rready_i,
    output logic                  usr_rsop_o,
    output logic                  usr_reop_o,
    output logic                  usr_rlast_o,
    output logic                  err_valid_o,
    output logic [2:0]            err_code_o,
    output logic [TAG_W-1:0]      err_tag_o
);
    localparam int NUM_TAGS = 2 ** TAG_W;
    localparam int LANES = DATA_W / 32;
    localparam int LW = $clog2(LANES);
    localparam int BC_W = $clog2(MAX_BYTES + 1);
    localparam logic [BC_W-1:0] B4K = BC_W'(4096);
    localparam logic [31:0] BPB = 32'(DATA_W / 8);
    localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, CHECK = 3'd2, STREAM = 3'd3, DROP = 3'd4;

    logic [2:0]       state;
    logic [TAG_W-1:0] h_tag;
    logic [2:0]       h_status;
    logic [15:0]      h_req_id;
    logic [11:0]      h_bc;
    logic [1:0]       h_la;
    logic [9:0]       h_len;
    logic             l_hit, l_active;
    logic [15:0]      l_req_id;
    logic [31:0]      l_addr;
    logic [9:0]       l_len;
    logic [BC_W-1:0]  l_rem;
    logic             active [NUM_TAGS];
    logic [BC_W-1:0]  rem [NUM_TAGS];
    logic [10:0]      cnt, len_dw, lm1;
    logic [BC_W-1:0]  len_bytes, total, exp, bc;
    logic [2:0]       chk_code;
    logic             streaming, hs, is_last, final_cpl, free_r, idle_err, chk_err, len_err;
    logic             unused;

    assign unused = ^cpl_lower_addr_i[6:2];
    assign len_dw = h_len == '0 ? 11'd1024 : {1'b0, h_len};
    assign lm1 = len_dw - 11'd1;
    assign len_bytes = BC_W'({len_dw, 2'b00});
    assign total = l_len == '0 ? B4K : BC_W'({l_len, 2'b00});
    assign exp = l_active ? l_rem : total;
    assign bc = h_bc == '0 ? B4K : BC_W'(h_bc);
    assign chk_code = h_status != 3'd0 ? 3'd1 :
                      !l_hit ? 3'd2 :
                      l_req_id != h_req_id ? 3'd3 :
                      bc != exp ? 3'd4 :
                      (h_la != 2'b00 || len_bytes > exp) ? 3'd5 : 3'd0;
    assign streaming = state == STREAM;
    assign hs = streaming && cpl_valid_i && usr_rready_i;
    assign is_last = cnt == (lm1 >> LW);
    assign final_cpl = exp == len_bytes;

    assign lookup_tag_o = h_tag;
    assign cpl_ready_o = state == DROP || (streaming && usr_rready_i) || idle_err;
    assign usr_rvalid_o = streaming && cpl_valid_i;
    assign usr_rtag_o = streaming ? h_tag : '0;
    assign usr_raddr_o = streaming ? l_addr + 32'(total - exp) + 32'(cnt) * BPB : '0;
    assign usr_rdata_o = streaming ? cpl_data_i : '0;
    // Only the computed last beat is partial; lanes above (len-1) mod LANES are masked.
    assign usr_rkeep_o = !streaming ? '0 : is_last ? ({LANES{1'b1}} >> ~lm1[LW-1:0]) : '1;
    assign usr_rsop_o = usr_rvalid_o && cnt == '0;
    assign usr_reop_o = usr_rvalid_o && (is_last || cpl_eop_i);
    assign usr_rlast_o = usr_reop_o && final_cpl;

    assign idle_err = state == IDLE && cpl_valid_i && !cpl_sop_i;
    assign chk_err = state == CHECK && chk_code != 3'd0;
    assign len_err = hs && (is_last != cpl_eop_i);
    assign err_valid_o = idle_err || chk_err || len_err;
    assign err_code_o = idle_err ? 3'd5 : chk_err ? chk_code : len_err ? 3'd6 : 3'd0;
    assign err_tag_o = idle_err ? cpl_tag_i : err_valid_o ? h_tag : '0;
    assign free_valid_o = free_r || (state == CHECK && chk_code == 3'd1);
    assign free_tag_o = free_valid_o ? h_tag : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            h_tag <= '0;
            h_status <= '0;
            h_req_id <= '0;
            h_bc <= '0;
            h_la <= '0;
            h_len <= '0;
            l_hit <= 1'b0;
            l_active <= 1'b0;
            l_req_id <= '0;
            l_addr <= '0;
            l_len <= '0;
            l_rem <= '0;
            cnt <= '0;
            free_r <= 1'b0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                active[i] <= 1'b0;
                rem[i] <= '0;
            end
        end else begin
            free_r <= hs && is_last && cpl_eop_i && final_cpl;
            case (state)
                IDLE: if (cpl_valid_i && cpl_sop_i) begin
                    h_tag <= cpl_tag_i;
                    h_status <= cpl_status_i;
                    h_req_id <= cpl_req_id_i;
                    h_bc <= cpl_byte_count_i;
                    h_la <= cpl_lower_addr_i[1:0];
                    h_len <= cpl_len_i;
                    state <= LOOKUP;
                end
                LOOKUP: begin
                    l_hit <= lookup_hit_i;
                    l_req_id <= lookup_req_id_i;
                    l_addr <= lookup_addr_i;
                    l_len <= lookup_len_i;
                    l_active <= active[h_tag];
                    l_rem <= rem[h_tag];
                    state <= CHECK;
                end
                CHECK: begin
                    cnt <= '0;
                    if (chk_code == 3'd1) active[h_tag] <= 1'b0;
                    state <= chk_code == 3'd0 ? STREAM : DROP;
                end
                STREAM: if (hs) begin
                    cnt <= cnt + 11'd1;
                    if (is_last && cpl_eop_i) begin
                        active[h_tag] <= !final_cpl;
                        if (!final_cpl) rem[h_tag] <= exp - len_bytes;
                        state <= IDLE;
                    end else if (cpl_eop_i) begin
                        state <= IDLE;
                    end else if (is_last) begin
                        state <= DROP;
                    end
                end
                DROP: if (cpl_valid_i && cpl_eop_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tl_cpl_assembler.sv
// tb_tl_cpl_assembler: table-driven completion vectors plus hand sequences for reset, latency and stray beats
module tb_tl_cpl_assembler;
    localparam int TAG_W = 5;
    localparam int DATA_W = 128;
    localparam int LANES = DATA_W / 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpl_valid_i, cpl_ready_o, cpl_sop_i, cpl_eop_i;
    logic [TAG_W-1:0] cpl_tag_i;
    logic [2:0] cpl_status_i;
    logic [15:0] cpl_req_id_i;
    logic [11:0] cpl_byte_count_i;
    logic [6:0] cpl_lower_addr_i;
    logic [9:0] cpl_len_i;
    logic [DATA_W-1:0] cpl_data_i;
    logic [TAG_W-1:0] lookup_tag_o, free_tag_o, usr_rtag_o, err_tag_o;
    logic lookup_hit_i, free_valid_o, usr_rvalid_o, usr_rready_i, usr_rsop_o, usr_reop_o, usr_rlast_o, err_valid_o;
    logic [15:0] lookup_req_id_i;
    logic [31:0] lookup_addr_i, usr_raddr_o;
    logic [9:0] lookup_len_i;
    logic [DATA_W-1:0] usr_rdata_o;
    logic [LANES-1:0] usr_rkeep_o;
    logic [2:0] err_code_o;

    tl_cpl_assembler #(.TAG_W(TAG_W), .DATA_W(DATA_W), .MAX_BYTES(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpl_valid_i(cpl_valid_i), .cpl_ready_o(cpl_ready_o), .cpl_sop_i(cpl_sop_i), .cpl_eop_i(cpl_eop_i),
        .cpl_tag_i(cpl_tag_i), .cpl_status_i(cpl_status_i), .cpl_req_id_i(cpl_req_id_i),
        .cpl_byte_count_i(cpl_byte_count_i), .cpl_lower_addr_i(cpl_lower_addr_i), .cpl_len_i(cpl_len_i),
        .cpl_data_i(cpl_data_i), .lookup_tag_o(lookup_tag_o), .lookup_hit_i(lookup_hit_i),
        .lookup_req_id_i(lookup_req_id_i), .lookup_addr_i(lookup_addr_i), .lookup_len_i(lookup_len_i),
        .free_tag_o(free_tag_o), .free_valid_o(free_valid_o), .usr_rtag_o(usr_rtag_o), .usr_raddr_o(usr_raddr_o),
        .usr_rdata_o(usr_rdata_o), .usr_rkeep_o(usr_rkeep_o), .usr_rvalid_o(usr_rvalid_o),
        .usr_rready_i(usr_rready_i), .usr_rsop_o(usr_rsop_o), .usr_reop_o(usr_reop_o), .usr_rlast_o(usr_rlast_o),
        .err_valid_o(err_valid_o), .err_code_o(err_code_o), .err_tag_o(err_tag_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag, status, rid, bc, la, len, nb, hit, t_rid;
        logic [31:0] t_addr;
        int t_len, e_beats;
        logic [31:0] e_base;
        int e_lkeep, e_reop, e_rlast, e_err, e_code, e_free;
    } vec_t;

    logic t_hit [32];
    logic [15:0] t_rid [32];
    logic [31:0] t_addr [32];
    logic [9:0] t_len [32];
    assign lookup_hit_i = t_hit[lookup_tag_o];
    assign lookup_req_id_i = t_rid[lookup_tag_o];
    assign lookup_addr_i = t_addr[lookup_tag_o];
    assign lookup_len_i = t_len[lookup_tag_o];

    int checks = 0, errors = 0, vi = 0;
    vec_t cv;
    int cyc = 0, m_beats = 0, m_bad = 0, m_reop = 0, m_rlast = 0, m_err = 0, m_code = 0, m_free = 0, m_t0 = 0, m_t1 = 0;
    int b_beats, b_bad, b_reop, b_rlast, b_err, b_free;

    // Expected address/keep/data per beat come from the current vector, not from the DUT.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (usr_rvalid_o && usr_rready_i) begin
                automatic int idx = m_beats - b_beats;
                automatic logic [31:0] dw = 32'hD000_0000 | 32'(idx);
                if (usr_raddr_o !== cv.e_base + 32'(idx) * 32'd16) m_bad++;
                if (usr_rkeep_o !== 4'(idx == cv.e_beats - 1 ? cv.e_lkeep : 'hF)) m_bad++;
                if (usr_rdata_o !== {LANES{dw}}) m_bad++;
                if (usr_rtag_o !== 5'(cv.tag) || usr_rsop_o !== (idx == 0)) m_bad++;
                if (usr_reop_o) begin
                    m_reop++;
                    if (idx != cv.e_beats - 1) m_bad++;
                end
                if (usr_rlast_o) m_rlast++;
                if (idx == 0) m_t0 = cyc;
                m_t1 = cyc;
                m_beats++;
            end
            if (err_valid_o) begin
                m_err++;
                m_code = int'(err_code_o);
                if (err_tag_o !== 5'(cv.tag)) m_bad++;
            end
            if (free_valid_o) begin
                m_free++;
                if (free_tag_o !== 5'(cv.tag)) m_bad++;
            end
        end
    end

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d expected %0d", n, vi, a, e);
        end
    endtask

    task automatic idle_bus();
        cpl_valid_i = 1'b0; cpl_sop_i = 1'b0; cpl_eop_i = 1'b0;
    endtask

    task automatic drive(input vec_t v, input int b);
        cpl_valid_i = 1'b1;
        cpl_sop_i = b == 0;
        cpl_eop_i = b == v.nb - 1;
        cpl_tag_i = 5'(v.tag);
        cpl_status_i = 3'(v.status);
        cpl_req_id_i = 16'(v.rid);
        cpl_byte_count_i = 12'(v.bc);
        cpl_lower_addr_i = 7'(v.la);
        cpl_len_i = 10'(v.len);
        cpl_data_i = {LANES{32'hD000_0000 | 32'(b)}};
    endtask

    task automatic accept();
        automatic int n = 0;
        automatic logic acc;
        do begin
            @(negedge clk);
            acc = cpl_ready_o;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout vec %0d", vi);
        end
    endtask

    task automatic prep(input vec_t v);
        t_hit[v.tag] = 1'(v.hit);
        t_rid[v.tag] = 16'(v.t_rid);
        t_addr[v.tag] = v.t_addr;
        t_len[v.tag] = 10'(v.t_len);
        cv = v;
        b_beats = m_beats; b_bad = m_bad; b_reop = m_reop; b_rlast = m_rlast; b_err = m_err; b_free = m_free;
    endtask

    task automatic compare(input vec_t v);
        repeat (3) @(posedge clk);
        #1;
        chk("beats", m_beats - b_beats, v.e_beats);
        chk("beat_fields", m_bad - b_bad, 0);
        chk("reop", m_reop - b_reop, v.e_reop);
        chk("rlast", m_rlast - b_rlast, v.e_rlast);
        chk("err_count", m_err - b_err, v.e_err);
        if (v.e_err != 0) chk("err_code", m_code, v.e_code);
        chk("free_count", m_free - b_free, v.e_free);
        if (v.e_beats > 1) chk("no_bubbles", m_t1 - m_t0, v.e_beats - 1);
    endtask

    task automatic run_vec(input vec_t v);
        prep(v);
        for (int b = 0; b < v.nb; b++) begin
            drive(v, b);
            accept();
        end
        idle_bus();
        compare(v);
    endtask

    vec_t vs [15];
    vec_t h;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        //         tag st rid    bc     la    len nb hit t_rid  t_addr        t_len bts base          lkeep reop rlast err code free
        vs[0]  = '{3,  0, 'h100, 'h100, 0,    64, 16, 1, 'h100, 32'h1000_0000, 64, 16, 32'h1000_0000, 'hF, 1, 1, 0, 0, 1};
        vs[1]  = '{4,  0, 'h100, 'h100, 0,    16, 4,  1, 'h100, 32'h2000_0000, 64, 4,  32'h2000_0000, 'hF, 1, 0, 0, 0, 0};
        vs[2]  = '{4,  0, 'h100, 'h0C0, 'h40, 48, 12, 1, 'h100, 32'h2000_0000, 64, 12, 32'h2000_0040, 'hF, 1, 1, 0, 0, 1};
        vs[3]  = '{5,  0, 'h100, 20,    0,    5,  2,  1, 'h100, 32'h3000_0010, 5,  2,  32'h3000_0010, 'h1, 1, 1, 0, 0, 1};
        vs[4]  = '{7,  0, 'h100, 64,    0,    8,  2,  1, 'h100, 32'h4000_0000, 16, 2,  32'h4000_0000, 'hF, 1, 0, 0, 0, 0};
        vs[5]  = '{7,  4, 'h100, 32,    0,    8,  2,  1, 'h100, 32'h4000_0000, 16, 0,  32'h0,         'hF, 0, 0, 1, 1, 1};
        vs[6]  = '{7,  0, 'h100, 64,    0,    16, 4,  1, 'h100, 32'h4000_0000, 16, 4,  32'h4000_0000, 'hF, 1, 1, 0, 0, 1};
        vs[7]  = '{8,  0, 'h100, 32,    0,    8,  2,  0, 'h100, 32'h4800_0000, 8,  0,  32'h0,         'hF, 0, 0, 1, 2, 0};
        vs[8]  = '{9,  0, 'h100, 128,   0,    32, 8,  1, 'h100, 32'h4C00_0000, 64, 0,  32'h0,         'hF, 0, 0, 1, 4, 0};
        vs[9]  = '{10, 0, 'h100, 32,    0,    8,  1,  1, 'h100, 32'h5000_0000, 8,  1,  32'h5000_0000, 'hF, 1, 1, 1, 6, 0};
        vs[10] = '{10, 0, 'h100, 32,    0,    8,  2,  1, 'h100, 32'h5000_0000, 8,  2,  32'h5000_0000, 'hF, 1, 1, 0, 0, 1};
        vs[11] = '{11, 0, 'h100, 16,    0,    4,  3,  1, 'h100, 32'h6000_0000, 4,  1,  32'h6000_0000, 'hF, 1, 1, 1, 6, 0};
        vs[12] = '{12, 0, 'h200, 16,    0,    4,  1,  1, 'h201, 32'h6100_0000, 4,  0,  32'h0,         'hF, 0, 0, 1, 3, 0};
        vs[13] = '{13, 0, 'h100, 16,    1,    4,  1,  1, 'h100, 32'h6200_0000, 4,  0,  32'h0,         'hF, 0, 0, 1, 5, 0};
        vs[14] = '{14, 0, 'h100, 16,    0,    8,  2,  1, 'h100, 32'h6300_0000, 4,  0,  32'h0,         'hF, 0, 0, 1, 5, 0};
        for (int i = 0; i < 32; i++) begin
            t_hit[i] = 1'b0; t_rid[i] = '0; t_addr[i] = '0; t_len[i] = '0;
        end
        idle_bus();
        cpl_tag_i = '0; cpl_status_i = '0; cpl_req_id_i = '0; cpl_byte_count_i = '0;
        cpl_lower_addr_i = '0; cpl_len_i = '0; cpl_data_i = '0;
        usr_rready_i = 1'b1;
        cv = vs[0];
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(cpl_ready_o), 0);
        chk("rst_rvalid", int'(usr_rvalid_o), 0);
        chk("rst_err", int'(err_valid_o), 0);
        chk("rst_free", int'(free_valid_o), 0);
        chk("rst_lookup_tag", int'(lookup_tag_o), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            vi = i;
            run_vec(vs[i]);
        end

        vi = 100;
        cv.tag = 2;
        cpl_valid_i = 1'b1; cpl_sop_i = 1'b0; cpl_eop_i = 1'b1; cpl_tag_i = 5'd2;
        @(negedge clk);
        chk("stray_ready", int'(cpl_ready_o), 1);
        chk("stray_err", int'(err_valid_o), 1);
        chk("stray_code", int'(err_code_o), 5);
        chk("stray_tag", int'(err_tag_o), 2);
        @(posedge clk);
        #1 idle_bus();

        vi = 101;
        h = '{16, 0, 'h100, 16, 0, 4, 1, 1, 'h100, 32'h7000_0000, 4, 1, 32'h7000_0000, 'hF, 1, 1, 0, 0, 1};
        prep(h);
        begin
            automatic int lat = -1;
            drive(h, 0);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (usr_rvalid_o) begin
                    lat = k;
                    break;
                end
            end
            @(posedge clk);
            #1 idle_bus();
            chk("latency", lat, 3);
        end
        compare(h);

        vi = 102;
        h = '{17, 0, 'h100, 64, 0, 4, 1, 1, 'h100, 32'h8000_0000, 16, 1, 32'h8000_0000, 'hF, 1, 0, 0, 0, 0};
        run_vec(h);
        vi = 103;
        h = '{17, 0, 'h100, 48, 16, 12, 3, 1, 'h100, 32'h8000_0000, 16, 3, 32'h8000_0010, 'hF, 1, 1, 0, 0, 1};
        prep(h);
        begin
            automatic int seen = 0;
            drive(h, 0);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (usr_rvalid_o) begin
                    seen = 1;
                    break;
                end
            end
            chk("mid_stream_reached", seen, 1);
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            idle_bus();
            @(negedge clk);
            chk("rst_mid_rvalid", int'(usr_rvalid_o), 0);
            chk("rst_mid_raddr", int'(usr_raddr_o), 0);
            chk("rst_mid_keep", int'(usr_rkeep_o), 0);
            chk("rst_mid_ready", int'(cpl_ready_o), 0);
            chk("rst_mid_err_free", int'(err_valid_o) + int'(free_valid_o), 0);
            @(posedge clk);
            #1 rst_n = 1'b1;
            @(posedge clk);
            #1;
        end
        vi = 104;
        h = '{17, 0, 'h100, 64, 0, 16, 4, 1, 'h100, 32'h8000_0000, 16, 4, 32'h8000_0000, 'hF, 1, 1, 0, 0, 1};
        run_vec(h);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
